// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: valid/ready binary load, sequential double-dabble BCD conversion,
// leading-zero blanking, overflow dashes and guarded digit scanning. Optional macro: SEG7_BRIGHTNESS_PWM_EN.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 16,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  load_valid,
`ifdef SEG7_BRIGHTNESS_PWM_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  load_ready,
    output logic                  overflow,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig
);

    // ceil(BIN_WIDTH*log10(2)) + 1, never less than the number of displayed digits
    localparam int unsigned BCD_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int unsigned BCD_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int unsigned BCD_W      = 4 * BCD_N;
    localparam int unsigned CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam int unsigned PH_W       = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state;
    logic [BIN_WIDTH-1:0]    bin_sr;
    logic [BCD_W-1:0]        bcd_sr;
    logic [BCD_W-1:0]        bcd_adj;
    logic [CNT_W-1:0]        bit_cnt;
    logic [NUM_DIGITS-1:0]   dp_cap;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    ovf_c;

    logic [PH_W-1:0]         phase;
    logic [PH_W-1:0]         phase_n;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_n;
    logic                    wrap;
    logic                    act_n;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              pat_c;
    logic [7:0]              slot_seg;
    logic [7:0]              slot_seg_n;
    logic [NUM_DIGITS-1:0]   slot_dig;
    logic [NUM_DIGITS-1:0]   slot_dig_n;
    logic [7:0]              seg_c;
    logic [NUM_DIGITS-1:0]   dig_c;
`ifdef SEG7_BRIGHTNESS_PWM_EN
    logic [3:0]              bright_q;
    logic [3:0]              bright_n;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    // Add-3 correction and overflow detection on the BCD accumulator
    always_comb begin
        bcd_adj = bcd_sr;
        ovf_c   = 1'b0;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
        for (int i = NUM_DIGITS; i < BCD_N; i++) begin
            if (bcd_sr[4*i +: 4] != 4'd0) ovf_c = 1'b1;
        end
    end

    // Load / convert / commit FSM; the display registers only change in COMMIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            bit_cnt    <= '0;
            dp_cap     <= '0;
            dp_reg     <= '0;
            disp       <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (load_valid && load_ready) begin
                        bin_sr     <= value;
                        bcd_sr     <= '0;
                        dp_cap     <= dp_mask;
                        bit_cnt    <= '0;
                        load_ready <= 1'b0;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt          <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BIN_WIDTH - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp       <= bcd_sr[4*NUM_DIGITS-1:0];
                    dp_reg     <= dp_cap;
                    overflow   <= ovf_c;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Leading-zero blanking, walking down from the leftmost digit
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
            blank[i] = zero_run && (i != 0);
        end
    end

    // Next scan position; the digit pattern is latched once per slot so pins never change mid-slot
    always_comb begin
        wrap    = (phase == PH_W'(SCAN_DIV - 1));
        phase_n = wrap ? '0 : phase + PH_W'(1);
        if (!wrap)                              idx_n = idx;
        else if (idx == IDX_W'(NUM_DIGITS - 1)) idx_n = '0;
        else                                    idx_n = idx + IDX_W'(1);
        pat_c      = overflow ? 7'h40 : (blank[idx_n] ? 7'h00 : seg_of(disp[4*idx_n +: 4]));
        slot_seg_n = wrap ? {dp_reg[idx_n], pat_c} : slot_seg;
        slot_dig_n = wrap ? (NUM_DIGITS'(1) << idx_n) : slot_dig;
`ifdef SEG7_BRIGHTNESS_PWM_EN
        bright_n = wrap ? brightness : bright_q;
        act_n    = (phase_n >= PH_W'(GUARD)) && (phase_n[PH_W-1 -: 4] <= bright_n);
`else
        act_n    = (phase_n >= PH_W'(GUARD));
`endif
        seg_c = act_n ? slot_seg_n : 8'h00;
        dig_c = act_n ? slot_dig_n : '0;
    end

    // Scan state and polarity-adjusted output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase    <= '0;
            idx      <= '0;
            slot_seg <= 8'h3F;
            slot_dig <= NUM_DIGITS'(1);
            seg      <= SEG_POL;
            dig      <= DIG_POL;
`ifdef SEG7_BRIGHTNESS_PWM_EN
            bright_q <= 4'hF;
`endif
        end else begin
            phase    <= phase_n;
            idx      <= idx_n;
            slot_seg <= slot_seg_n;
            slot_dig <= slot_dig_n;
            seg      <= seg_c ^ SEG_POL;
            dig      <= dig_c ^ DIG_POL;
`ifdef SEG7_BRIGHTNESS_PWM_EN
            bright_q <= bright_n;
`endif
        end
    end

endmodule
